// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single-bullet controller for one tank.
//
// Spawns a bullet at the tank centre on a rising fire edge, advances it SPEED
// pixels per frame tick in the direction latched at spawn, and tests the
// bullet box against the tile map while the raster scans it. The first
// destroyable pixel hit produces a one-cycle combinational collide strobe for
// the map renderer; any hard pixel stops the bullet at the next frame tick.
//
// Optional feature macro: BULLET_EXPLOSION_EN
//   defined   - hit bullets enter EXPLODE for EXPLODE_FRAMES frame ticks and
//               draw a 2*BULLET_SIZE orange square centred on the bullet.
//   undefined - hit bullets return straight to IDLE on the next frame tick.
//
// Ports:
//   clk_i, rst_ni                 pixel clock, async active-low reset
//   frame_tick_i                  one-cycle pulse per frame (vertical blank)
//   fire_i                        fire button level
//   tank_x_i, tank_y_i            tank 32x32 top-left pixel
//   tank_dir_i                    00 up, 01 right, 10 down, 11 left
//   hpos_i, vpos_i                current raster pixel
//   display_enable_i              raster in visible area
//   destroyable_block_i           current pixel is a damageable brick
//   all_hard_block_i              current pixel is brick, wall or border
//   bullet_collide_o              strobe on first destroyable pixel hit
//   bullet_enable_o               bullet/explosion covers current pixel
//   bullet_blue_o/green_o/red_o   pixel colour, 0 when not enabled
//   bullet_active_o               controller is not IDLE
module bullet_ctrl #(
  parameter int unsigned            COLOR_BITS     = 24,
  parameter int unsigned            BULLET_SIZE    = 4,
  parameter int unsigned            SPEED          = 4,
  parameter int unsigned            EXPLODE_FRAMES = 8,
  parameter logic [COLOR_BITS-1:0]  BULLET_COLOR   = 24'hFFFFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frame_tick_i,
  input  logic                    fire_i,
  input  logic [9:0]              tank_x_i,
  input  logic [9:0]              tank_y_i,
  input  logic [1:0]              tank_dir_i,
  input  logic [9:0]              hpos_i,
  input  logic [9:0]              vpos_i,
  input  logic                    display_enable_i,
  input  logic                    destroyable_block_i,
  input  logic                    all_hard_block_i,
  output logic                    bullet_collide_o,
  output logic                    bullet_enable_o,
  output logic [COLOR_BITS/3-1:0] bullet_blue_o,
  output logic [COLOR_BITS/3-1:0] bullet_green_o,
  output logic [COLOR_BITS/3-1:0] bullet_red_o,
  output logic                    bullet_active_o
);

  localparam int unsigned CW = COLOR_BITS / 3;

  localparam logic [9:0]         SPAWN_OFF = 10'(16 - BULLET_SIZE / 2);
  localparam logic [10:0]        BOX_EXT   = 11'(BULLET_SIZE - 1);
  localparam logic signed [10:0] STEP      = 11'(SPEED);
  localparam logic signed [10:0] MAX_X     = 11'(640 - BULLET_SIZE);
  localparam logic signed [10:0] MAX_Y     = 11'(480 - BULLET_SIZE);

  localparam logic [CW-1:0] FLY_B = BULLET_COLOR[3*CW-1:2*CW];
  localparam logic [CW-1:0] FLY_G = BULLET_COLOR[2*CW-1:CW];
  localparam logic [CW-1:0] FLY_R = BULLET_COLOR[CW-1:0];

  if (EXPLODE_FRAMES < 1) begin : g_bad_explode_frames
    $error("EXPLODE_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    EXPLODE
  } state_t;

  state_t     state;
  logic [9:0] bx;
  logic [9:0] by;
  logic [1:0] dir_q;
  logic       hit_q;
  logic       fire_q;

  logic               fire_edge;
  logic               overlap;
  logic               hit_set;
  logic               hit_now;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic               out_of_field;

  assign fire_edge = fire_i & ~fire_q;

  // 11-bit compares so bx + BULLET_SIZE - 1 cannot wrap near the edge.
  assign overlap = display_enable_i
                 && ({1'b0, hpos_i} >= {1'b0, bx})
                 && ({1'b0, hpos_i} <= ({1'b0, bx} + BOX_EXT))
                 && ({1'b0, vpos_i} >= {1'b0, by})
                 && ({1'b0, vpos_i} <= ({1'b0, by} + BOX_EXT));

  assign hit_set          = (state == FLYING) && overlap && all_hard_block_i && !hit_q;
  assign hit_now          = hit_q | hit_set;
  assign bullet_collide_o = (state == FLYING) && overlap && destroyable_block_i && !hit_q;
  assign bullet_active_o  = (state != IDLE);

  always_comb begin
    nx = {1'b0, bx};
    ny = {1'b0, by};
    case (dir_q)
      2'b00:   ny = ny - STEP;
      2'b01:   nx = nx + STEP;
      2'b10:   ny = ny + STEP;
      default: nx = nx - STEP;
    endcase
    out_of_field = (nx < 11'sd0) || (nx > MAX_X) || (ny < 11'sd0) || (ny > MAX_Y);
  end

`ifdef BULLET_EXPLOSION_EN
  localparam int unsigned        CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic signed [11:0] HALF = 12'(BULLET_SIZE / 2);
  localparam logic signed [11:0] SPAN = 12'(2 * BULLET_SIZE - 1);
  localparam logic [CW-1:0]      EXP_B = '0;
  localparam logic [CW-1:0]      EXP_G = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0]      EXP_R = '1;

  logic [CNT_W-1:0]   frame_cnt;
  logic signed [11:0] hs;
  logic signed [11:0] vs;
  logic signed [11:0] ex_x0;
  logic signed [11:0] ex_y0;
  logic               in_blast;

  // Signed so the blast square may extend past the left/top screen edge.
  always_comb begin
    hs       = {2'b00, hpos_i};
    vs       = {2'b00, vpos_i};
    ex_x0    = {2'b00, bx} - HALF;
    ex_y0    = {2'b00, by} - HALF;
    in_blast = display_enable_i
            && (hs >= ex_x0) && (hs <= ex_x0 + SPAN)
            && (vs >= ex_y0) && (vs <= ex_y0 + SPAN);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      bx     <= '0;
      by     <= '0;
      dir_q  <= '0;
      hit_q  <= 1'b0;
      // Reset value of 1 treats the button as held, so a button held
      // through reset must be released and pressed again to fire.
      fire_q <= 1'b1;
`ifdef BULLET_EXPLOSION_EN
      frame_cnt <= '0;
`endif
    end else begin
      fire_q <= fire_i;
      case (state)
        IDLE: begin
          if (fire_edge) begin
            bx    <= tank_x_i + SPAWN_OFF;
            by    <= tank_y_i + SPAWN_OFF;
            dir_q <= tank_dir_i;
            hit_q <= 1'b0;
            state <= FLYING;
          end
        end
        FLYING: begin
          if (frame_tick_i) begin
            if (hit_now) begin
`ifdef BULLET_EXPLOSION_EN
              hit_q     <= 1'b1;
              frame_cnt <= '0;
              state     <= EXPLODE;
`else
              state     <= IDLE;
`endif
            end else if (out_of_field) begin
              state <= IDLE;
            end else begin
              bx <= nx[9:0];
              by <= ny[9:0];
            end
          end else if (hit_set) begin
            hit_q <= 1'b1;
          end
        end
`ifdef BULLET_EXPLOSION_EN
        EXPLODE: begin
          if (frame_tick_i) begin
            if (frame_cnt == CNT_LAST) begin
              state <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bullet_enable_o = 1'b0;
    bullet_blue_o   = '0;
    bullet_green_o  = '0;
    bullet_red_o    = '0;
    case (state)
      FLYING: begin
        if (overlap) begin
          bullet_enable_o = 1'b1;
          bullet_blue_o   = FLY_B;
          bullet_green_o  = FLY_G;
          bullet_red_o    = FLY_R;
        end
      end
`ifdef BULLET_EXPLOSION_EN
      EXPLODE: begin
        if (in_blast) begin
          bullet_enable_o = 1'b1;
          bullet_blue_o   = EXP_B;
          bullet_green_o  = EXP_G;
          bullet_red_o    = EXP_R;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule
